vga_plot_sink: RTL and testbench

Receiving end of the plot interface that drawing engines (circle, line, fill) drive through vga_x, vga_y, vga_colour and vga_plot.
- Clips each plot request to the 160x120 screen.
- Buffers accepted pixels in a small FIFO.
- Issues framebuffer writes over a valid/ready memory port with address y*160+x.
- Sits between the drawing engines and the framebuffer RAM.
- Drawing engines have no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/plot_fifo.sv | 53 +++++
 rtl/vga_plot_sink.sv | 117 +++++++++++
 tb/tb_vga_plot_sink.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the plot sink: screen geometry, pixel bundle, write FSM.
// Address helper maps (x,y) to the linear framebuffer word address.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0]  vga_x_t;
  typedef logic [6:0]  vga_y_t;
  typedef logic [2:0]  colour_t;
  typedef logic [14:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    colour_t  colour;
  } pixel_t;

  typedef enum logic {
    WR_IDLE,
    WR_ISSUE
  } wr_state_e;

  // y*160 + x using shifts only
  function automatic fb_addr_t pix_addr(vga_x_t x, vga_y_t y);
    return (fb_addr_t'(y) << 7)
         + (fb_addr_t'(y) << 5)
         + fb_addr_t'(x);
  endfunction

  function automatic logic [15:0] sat_cnt(
    logic [15:0] cur,
    logic        ev,
    logic        clr
  );
    if (clr)
      return ev ? 16'd1 : 16'd0;
    if (ev && cur != 16'hFFFF)
      return cur + 16'd1;
    return cur;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous pixel FIFO; head is presented combinationally on rdata_o.
// A push is allowed when full if a pop happens on the same edge.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  pixel_t wdata_i,
  input  logic   pop_i,
  output pixel_t rdata_o,
  output logic   empty_o,
  output logic   full_o,
  output logic   last_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  pixel_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign last_o  = (cnt_q == CW'(1));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push)
        wptr_q <= wptr_q + AW'(1);
      if (do_pop)
        rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_plot_sink.sv
// Clips plot requests, queues pixels and writes them to the framebuffer.
// Define PLOT_STATS_EN to add saturating plotted/clipped/dropped counters.
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        busy,
  output logic        overflow,
  input  logic        clear_ovf
`ifdef PLOT_STATS_EN
  ,
  output logic [15:0] stat_plotted,
  output logic [15:0] stat_clipped,
  output logic [15:0] stat_dropped
`endif
);

  wr_state_e state_q, state_d;
  pixel_t    in_pix, head;
  logic      in_range, req, clipped;
  logic      done, push, drop;
  logic      empty, full, last;
  logic      ovf_q;

  assign in_range = (vga_x < vga_x_t'(SCREEN_W))
                 && (vga_y < vga_y_t'(SCREEN_H));
  assign req      = vga_plot && in_range;
  assign clipped  = vga_plot && !in_range;

  assign in_pix.addr   = pix_addr(vga_x, vga_y);
  assign in_pix.colour = vga_colour;

  assign done = (state_q == WR_ISSUE) && fb_ready;
  assign push = req && (!full || done);
  assign drop = req && full && !done;

  plot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_pix),
    .pop_i   (done),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= WR_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE:  if (!empty) state_d = WR_ISSUE;
      WR_ISSUE: if (done && last && !push) state_d = WR_IDLE;
      default:  state_d = WR_IDLE;
    endcase
  end

  // outputs read zero whenever no write is offered
  assign fb_we    = (state_q == WR_ISSUE);
  assign fb_addr  = fb_we ? head.addr : '0;
  assign fb_wdata = fb_we ? head.colour : '0;
  assign busy     = !empty || fb_we;
  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (clear_ovf)
      ovf_q <= 1'b0;
  end

`ifdef PLOT_STATS_EN
  logic [15:0] plot_q, clip_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      plot_q <= '0;
      clip_q <= '0;
      drop_q <= '0;
    end else begin
      plot_q <= sat_cnt(plot_q, done, clear_ovf);
      clip_q <= sat_cnt(clip_q, clipped, clear_ovf);
      drop_q <= sat_cnt(drop_q, drop, clear_ovf);
    end
  end

  assign stat_plotted = plot_q;
  assign stat_clipped = clip_q;
  assign stat_dropped = drop_q;
`else
  logic unused_clip;
  assign unused_clip = clipped;
`endif

endmodule

// File: tb/tb_vga_plot_sink.sv
// Randomised + directed bench for vga_plot_sink with a queue scoreboard.
// Reference model tracks occupancy and expected writes per spec rules.
module tb_vga_plot_sink;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        fb_ready = 1'b0;
  logic        busy;
  logic        overflow;
  logic        clear_ovf = 1'b0;
`ifdef PLOT_STATS_EN
  logic [15:0] stat_plotted, stat_clipped, stat_dropped;
`endif

  vga_plot_sink #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
`ifdef PLOT_STATS_EN
    ,
    .stat_plotted (stat_plotted),
    .stat_clipped (stat_clipped),
    .stat_dropped (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int col;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   wr_cnt = 0;
  int   last_addr = -1;
  bit   mon_en = 1'b0;

  // reference model state
  int   m_cnt = 0;
  bit   m_we = 1'b0;
  bit   m_ovf = 1'b0;
  int   m_plot = 0, m_clip = 0, m_drop = 0;

  task automatic chk(input string n, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, got, want, $time);
    end
  endtask

  function automatic int sat(input int cur, input bit ev, input bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev && cur < 65535) return cur + 1;
    return cur;
  endfunction

  task automatic model(input bit r, input bit pl, input int x, input int y,
                       input int c, input bit rdy, input bit clr);
    bit done, inr, drop, clip;
    int prev;
    if (r) begin
      m_cnt = 0; m_we = 0; m_ovf = 0;
      m_plot = 0; m_clip = 0; m_drop = 0;
      exp_q.delete();
      return;
    end
    done = m_we && rdy;
    prev = m_cnt;
    if (done) m_cnt--;
    inr  = (x < 160) && (y < 120);
    clip = pl && !inr;
    drop = 0;
    if (pl && inr) begin
      if (prev < DEPTH || done) begin
        exp_q.push_back('{addr: y * 160 + x, col: c});
        m_cnt++;
      end else begin
        drop = 1;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_we = m_we ? (m_cnt > 0) : (prev > 0);
    m_plot = sat(m_plot, done, clr);
    m_clip = sat(m_clip, clip, clr);
    m_drop = sat(m_drop, drop, clr);
  endtask

  task automatic step(input bit r, input bit pl, input int x, input int y,
                      input int c, input bit rdy, input bit clr);
    rst        = r;
    vga_plot   = pl;
    vga_x      = x[7:0];
    vga_y      = y[6:0];
    vga_colour = c[2:0];
    fb_ready   = rdy;
    clear_ovf  = clr;
    @(posedge clk);
    model(r, pl, x, y, c, rdy, clr);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy, 0);
  endtask

  // monitor: flags against model, writes against scoreboard queue
  always @(negedge clk) begin
    if (mon_en) begin
      chk("fb_we", int'(fb_we), int'(m_we));
      chk("busy", int'(busy), int'((m_cnt > 0) || m_we));
      chk("overflow", int'(overflow), int'(m_ovf));
`ifdef PLOT_STATS_EN
      chk("stat_plotted", int'(stat_plotted), m_plot);
      chk("stat_clipped", int'(stat_clipped), m_clip);
      chk("stat_dropped", int'(stat_dropped), m_drop);
`endif
      if (fb_we && fb_ready) begin
        wr_cnt++;
        last_addr = int'(fb_addr);
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                   fb_addr, fb_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(fb_addr), e.addr);
          chk("wr_data", int'(fb_wdata), e.col);
        end
      end
    end
  end

  int w0;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    chk("rst_we", int'(fb_we), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_wdata", int'(fb_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);

    // single pixel latency
    step(0, 1, 80, 60, 2, 1, 0);
    chk("lat_we_k", int'(fb_we), 0);
    idle(1, 1);
    chk("lat_we_k1", int'(fb_we), 1);
    chk("single_addr", int'(fb_addr), 9680);
    chk("single_data", int'(fb_wdata), 2);
    idle(1, 1);
    chk("single_busy", int'(busy), 0);

    // corners and clipping
    w0 = wr_cnt;
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 159, 119, 5, 1, 0);
    step(0, 1, 160, 0, 6, 1, 0);
    step(0, 1, 0, 120, 7, 1, 0);
    idle(1, 4);
    chk("corner_writes", wr_cnt - w0, 2);
    chk("corner_last", last_addr, 19199);
    chk("corner_ovf", int'(overflow), 0);

    // backpressure
    step(0, 1, 10, 1, 3, 0, 0);
    step(0, 1, 11, 1, 4, 0, 0);
    step(0, 1, 12, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 1);
      chk("stall_addr", int'(fb_addr), 170);
      chk("stall_data", int'(fb_wdata), 3);
    end
    w0 = wr_cnt;
    idle(1, 3);
    chk("release_writes", wr_cnt - w0, 3);
    chk("release_last", last_addr, 172);
    idle(1, 1);

    // overflow
    for (int i = 0; i < 6; i++) step(0, 1, 20 + i, 2, i, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    w0 = wr_cnt;
    idle(1, 6);
    chk("ovf_writes", wr_cnt - w0, 4);
    chk("ovf_last", last_addr, 343);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("ovf_clear", int'(overflow), 0);

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) step(0, 1, 30 + i, 3, i, 0, 0);
    w0 = wr_cnt;
    step(0, 1, 40, 3, 7, 1, 0);
    chk("fullpop_ovf", int'(overflow), 0);
    idle(1, 6);
    chk("fullpop_writes", wr_cnt - w0, 5);
    chk("fullpop_last", last_addr, 520);

    // reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, 50 + i, 4, i, 0, 0);
    idle(0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midrst_we", int'(fb_we), 0);
    chk("midrst_busy", int'(busy), 0);
    w0 = wr_cnt;
    idle(1, 4);
    chk("midrst_writes", wr_cnt - w0, 0);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 175)),
           int'($urandom_range(0, 127)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0));
    end
    idle(1, DEPTH + 4);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
